shift_rows_pipe: RTL and testbench

Parametrised, pipelined ShiftRows / InvShiftRows unit for the Rijndael state path, supporting 4-, 6- and 8-column states. A per-block `mode` input selects the forward or inverse permutation. The block sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns. It uses a 2-entry elastic buffer with a valid/ready handshake on both sides, so upstream stalls never depend combinationally on downstream ready.

---
 rtl/shift_rows_pipe_if.sv | 26 ++
 rtl/shift_rows_pipe.sv | 98 +++++++++
 tb/tb_shift_rows_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_rows_pipe_if.sv
// Stream bundle for shift_rows_pipe: input and output valid/ready handshakes with state and mode.
// The slave modport is the pipe's view; the master modport is the surrounding datapath's view.
interface shift_rows_pipe_if #(
  parameter int NB = 4
);
  localparam int W = 32 * NB;

  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for 4/6/8-column Rijndael states behind a 2-entry elastic buffer.
// Optional accepted-block counter: define SHIFT_ROWS_PIPE_CNT_EN to enable blk_cnt.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_rows_pipe_if.slave bus,
  output logic [31:0]      blk_cnt
);
  localparam int W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Row offsets: NB=8 skips offset 2, giving {0,1,3,4}.
  function automatic int shift_of(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [W-1:0] perm;
  logic [W-1:0] mem_data [2];
  logic         mem_mode [2];
  logic [1:0]   cnt;
  logic [1:0]   cnt_next;
  logic         wp;
  logic         rp;
  logic         in_ready_q;
  logic         accept;
  logic         release_blk;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    perm = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (bus.in_mode)
          perm[W-1-32*c-8*r -: 8] = bus.in_data[W-1-32*((c+NB-shift_of(r))%NB)-8*r -: 8];
        else
          perm[W-1-32*c-8*r -: 8] = bus.in_data[W-1-32*((c+shift_of(r))%NB)-8*r -: 8];
      end
    end
  end

  assign accept      = bus.in_valid && in_ready_q;
  assign release_blk = bus.out_valid && bus.out_ready;

  always_comb begin
    cnt_next = cnt;
    if (accept && !release_blk)
      cnt_next = cnt + 2'd1;
    else if (!accept && release_blk)
      cnt_next = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      cnt        <= 2'd0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      in_ready_q <= 1'b0;
      // NOTE: the buffer entries are reset too, because out_data reads entry[rp] and must be 0 after reset.
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_mode[i] <= 1'b0;
      end
    end else begin
      cnt        <= cnt_next;
      in_ready_q <= (cnt_next < 2'd2);
      if (accept) begin
        mem_data[wp] <= perm;
        mem_mode[wp] <= bus.in_mode;
        wp           <= ~wp;
      end
      if (release_blk)
        rp <= ~rp;
    end
  end

  // in_ready is a register, so downstream ready never reaches upstream combinationally.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_data  = mem_data[rp];
  assign bus.out_mode  = mem_mode[rp];

`ifdef SHIFT_ROWS_PIPE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      blk_cnt <= 32'h0;
    else if (accept)
      blk_cnt <= blk_cnt + 32'd1;
  end
`else
  assign blk_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed self-checking bench for shift_rows_pipe (NB=4 and NB=8 instances).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_shift_rows_pipe;
  logic clk;
  logic rst_n;
  logic [31:0] blk_cnt4;
  logic [31:0] blk_cnt8;
  int n_checks;
  int n_fail;

`ifdef SHIFT_ROWS_PIPE_CNT_EN
  localparam logic [31:0] EXP_CNT8 = 32'd8;
`else
  localparam logic [31:0] EXP_CNT8 = 32'd0;
`endif

  localparam logic [127:0] X     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Y     = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] Z     = 128'h0009020b040d060f08010a030c050e07;
  localparam logic [127:0] F_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] F_OUT = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;

  shift_rows_pipe_if #(.NB(4)) bus4 ();
  shift_rows_pipe_if #(.NB(8)) bus8 ();

  shift_rows_pipe #(.NB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave), .blk_cnt(blk_cnt4));
  shift_rows_pipe #(.NB(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave), .blk_cnt(blk_cnt8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte8(input logic [255:0] d, input int r, input int c);
    return d[255-32*c-8*r -: 8];
  endfunction

  // Offer one block to the empty NB=4 pipe and check it one cycle later.
  task automatic send_one(input string tag, input logic m, input logic [127:0] d, input logic [127:0] e);
    bus4.in_valid  = 1'b1;
    bus4.in_mode   = m;
    bus4.in_data   = d;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check({tag, "_valid"}, bus4.out_valid, 1'b1);
    check({tag, "_data"}, bus4.out_data, e);
    check({tag, "_mode"}, bus4.out_mode, m);
    @(negedge clk);
    check({tag, "_drained"}, bus4.out_valid, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] mx_in  [8];
    logic [127:0] mx_exp [8];
    logic         mx_mode[8];
    logic [255:0] d8;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_mode = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_in_ready", bus4.in_ready, 1'b0);
    check("rst_out_data", bus4.out_data, 128'h0);
    check("rst_out_mode", bus4.out_mode, 1'b0);
    check("rst_blk_cnt", blk_cnt4, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready_rise", bus4.in_ready, 1'b1);

    // Single blocks through an empty buffer
    send_one("fips_inv", 1'b1, F_IN, F_OUT);
    send_one("fwd", 1'b0, X, Y);
    send_one("round_trip", 1'b1, Y, X);

    // Mixed modes at full rate
    mx_mode[0] = 1'b0; mx_in[0] = X;    mx_exp[0] = Y;
    mx_mode[1] = 1'b1; mx_in[1] = F_IN; mx_exp[1] = F_OUT;
    mx_mode[2] = 1'b0; mx_in[2] = Y;    mx_exp[2] = Z;
    mx_mode[3] = 1'b1; mx_in[3] = Y;    mx_exp[3] = X;
    for (int i = 4; i < 8; i++) begin
      mx_mode[i] = mx_mode[i-4]; mx_in[i] = mx_in[i-4]; mx_exp[i] = mx_exp[i-4];
    end
    pulse_reset();
    bus4.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("mix%0d_valid", i-1), bus4.out_valid, 1'b1);
        check($sformatf("mix%0d_data", i-1), bus4.out_data, mx_exp[i-1]);
        check($sformatf("mix%0d_mode", i-1), bus4.out_mode, mx_mode[i-1]);
      end
      if (i < 8) begin
        check($sformatf("mix%0d_in_ready", i), bus4.in_ready, 1'b1);
        bus4.in_valid = 1'b1;
        bus4.in_mode  = mx_mode[i];
        bus4.in_data  = mx_in[i];
      end else begin
        bus4.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("mix_drained", bus4.out_valid, 1'b0);
    check("mix_blk_cnt", blk_cnt4, EXP_CNT8);

    // Backpressure: two blocks fill the buffer, the third is refused
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = X;
    check("bp_ready0", bus4.in_ready, 1'b1);
    @(negedge clk);
    check("bp_ready1", bus4.in_ready, 1'b1);
    check("bp_head1", bus4.out_data, Y);
    bus4.in_mode = 1'b1; bus4.in_data = F_IN;
    @(negedge clk);
    check("bp_full_ready", bus4.in_ready, 1'b0);
    check("bp_head2", bus4.out_data, Y);
    bus4.in_mode = 1'b0; bus4.in_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    @(negedge clk);
    check("bp_refused_ready", bus4.in_ready, 1'b0);
    check("bp_hold_data", bus4.out_data, Y);
    check("bp_hold_mode", bus4.out_mode, 1'b0);
    check("bp_hold_valid", bus4.out_valid, 1'b1);
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("bp_blk2_valid", bus4.out_valid, 1'b1);
    check("bp_blk2_data", bus4.out_data, F_OUT);
    check("bp_blk2_mode", bus4.out_mode, 1'b1);
    check("bp_ready_back", bus4.in_ready, 1'b1);
    @(negedge clk);
    check("bp_drained", bus4.out_valid, 1'b0);

    // NB=8: offsets {0,1,3,4}
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        d8[255-32*c-8*r -: 8] = 8'(16*c + r);
    d8[255-32*4-8*3 -: 8] = 8'hA5;
    bus8.in_valid = 1'b1; bus8.in_mode = 1'b0; bus8.in_data = d8;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("nb8_fwd_valid", bus8.out_valid, 1'b1);
    check("nb8_fwd_r3c0", byte8(bus8.out_data, 3, 0), 8'hA5);
    check("nb8_fwd_r2c0", byte8(bus8.out_data, 2, 0), 8'h32);
    check("nb8_fwd_r1c0", byte8(bus8.out_data, 1, 0), 8'h11);
    check("nb8_fwd_r3c4", byte8(bus8.out_data, 3, 4), 8'h03);
    check("nb8_fwd_r0c5", byte8(bus8.out_data, 0, 5), 8'h50);
    check("nb8_fwd_mode", bus8.out_mode, 1'b0);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_mode = 1'b1; bus8.in_data = d8;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("nb8_inv_valid", bus8.out_valid, 1'b1);
    check("nb8_inv_r3c0", byte8(bus8.out_data, 3, 0), 8'hA5);
    check("nb8_inv_r2c0", byte8(bus8.out_data, 2, 0), 8'h52);
    check("nb8_inv_r1c0", byte8(bus8.out_data, 1, 0), 8'h71);
    check("nb8_inv_r2c3", byte8(bus8.out_data, 2, 3), 8'h02);
    check("nb8_inv_mode", bus8.out_mode, 1'b1);
    @(negedge clk);

    // Reset with a full buffer and an input still offered
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.in_data = X;
    @(negedge clk);
    bus4.in_mode = 1'b1; bus4.in_data = Y;
    @(negedge clk);
    check("full_in_ready", bus4.in_ready, 1'b0);
    check("full_out_valid", bus4.out_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus4.out_valid, 1'b0);
    check("midrst_out_data", bus4.out_data, 128'h0);
    check("midrst_out_mode", bus4.out_mode, 1'b0);
    check("midrst_blk_cnt", blk_cnt4, 32'h0);
    check("midrst_in_ready", bus4.in_ready, 1'b0);
    rst_n = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", bus4.in_ready, 1'b1);
    check("postrst_out_valid", bus4.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
